// File: rtl/uart_receiver.sv
// 8N1 UART receiver with an internal oversampling tick, mid-bit sampling,
// and a held ready/ack handshake carrying framing and overrun flags.
module uart_receiver #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned OVERSAMPLE  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_ready,
    input  logic       data_ack,
    output logic       framing_error,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int unsigned DIV_RAW = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SCW     = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]  TICK_LAST = TW'(DIV - 1);
    localparam logic [SCW-1:0] SC_HALF   = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] SC_LAST   = SCW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t         state;
    logic           rx_meta;
    logic           rx_s;
    logic [TW-1:0]  tcnt;
    logic           tick;
    logic [SCW-1:0] sc;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic           deliver;
    logic           ack_c;

    // Two-flop synchronizer; idle-high so reset never looks like a start bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Free-running divider; START is only entered on a tick, so the wrap
    // there already restarts the count from 0
    assign tick = (tcnt == TICK_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt <= '0;
        end else if (tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    // Frame FSM: all counting and sampling on tick cycles only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            sc            <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            deliver       <= 1'b0;
            framing_error <= 1'b0;
            rx_busy       <= 1'b0;
        end else begin
            deliver       <= 1'b0;
            framing_error <= 1'b0;
            if (tick) begin
                case (state)
                    S_IDLE: begin
                        if (!rx_s) begin
                            state   <= S_START;
                            sc      <= '0;
                            rx_busy <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (sc == SC_HALF) begin
                            if (rx_s) begin
                                state   <= S_IDLE;
                                rx_busy <= 1'b0;
                            end else begin
                                sc      <= '0;
                                bit_idx <= '0;
                                state   <= S_DATA;
                            end
                        end else begin
                            sc <= sc + SCW'(1);
                        end
                    end
                    S_DATA: begin
                        if (sc == SC_LAST) begin
                            shreg   <= {rx_s, shreg[7:1]};
                            sc      <= '0;
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                state <= S_STOP;
                            end
                        end else begin
                            sc <= sc + SCW'(1);
                        end
                    end
                    S_STOP: begin
                        if (sc == SC_LAST) begin
                            sc <= '0;
                            if (rx_s) begin
                                deliver <= 1'b1;
                                state   <= S_IDLE;
                                rx_busy <= 1'b0;
                            end else begin
                                framing_error <= 1'b1;
                                state         <= S_BREAK;
                            end
                        end else begin
                            sc <= sc + SCW'(1);
                        end
                    end
                    S_BREAK: begin
                        if (rx_s) begin
                            state   <= S_IDLE;
                            rx_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        rx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Handshake: an ack in the delivery cycle frees the slot for the new byte
    assign ack_c = data_ready & data_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out   <= 8'h00;
            data_ready <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (ack_c) begin
                data_ready <= 1'b0;
                overrun    <= 1'b0;
            end
            if (deliver) begin
                if (!data_ready || ack_c) begin
                    data_out   <= shreg;
                    data_ready <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule
